// File: rtl/me_best_match_comparator.sv
// Motion-estimation best-match comparator: tracks the minimum PE distance
// per search window. Optional early exit on zero distance: COMP_EARLY_EXIT_EN.
module me_best_match_comparator #(
    parameter int NUM_PE     = 16,
    parameter int DIST_W     = 8,
    parameter int VEC_W      = 4,
    parameter int CAND_BEATS = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      compstart,
    input  logic [NUM_PE*DIST_W-1:0]  peout,
    input  logic [NUM_PE-1:0]         peready,
    input  logic [VEC_W-1:0]          vectorx,
    input  logic [VEC_W-1:0]          vectory,
    output logic [DIST_W-1:0]         bestdist,
    output logic [VEC_W-1:0]          motionx,
    output logic [VEC_W-1:0]          motiony,
    output logic [$clog2(NUM_PE)-1:0] bestpe,
    output logic                      bestvalid,
    output logic                      busy,
    output logic                      compdone
);

    localparam int PE_W  = $clog2(NUM_PE);
    localparam int CNT_W = $clog2(CAND_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DRAIN
    } state_t;

    state_t state_q, state_d;
    logic   busy_d, done_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              beat;
    logic              last_beat;

    logic              sel_found;
    logic [DIST_W-1:0] sel_dist;
    logic [PE_W-1:0]   sel_lane;

    logic              s1_valid;
    logic [DIST_W-1:0] s1_dist;
    logic [PE_W-1:0]   s1_lane;
    logic [VEC_W-1:0]  s1_vx;
    logic [VEC_W-1:0]  s1_vy;

    logic              s2_hit;
    logic              early_exit;

    // A beat only counts in SEARCH; compstart discards a coincident beat.
    assign beat      = (state_q == SEARCH) && (|peready) && !compstart;
    assign last_beat = beat && (cnt_q == CNT_W'(CAND_BEATS - 1));
    assign s2_hit    = s1_valid && (s1_dist < bestdist);

`ifdef COMP_EARLY_EXIT_EN
    assign early_exit = s2_hit && (s1_dist == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Minimum over the ready lanes; strict compare keeps the lowest lane on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_dist  = '1;
        sel_lane  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (peready[i] &&
                (!sel_found || (peout[i*DIST_W +: DIST_W] < sel_dist))) begin
                sel_found = 1'b1;
                sel_dist  = peout[i*DIST_W +: DIST_W];
                sel_lane  = PE_W'(i);
            end
        end
    end

    // Next-state and framing outputs; compstart wins over everything.
    always_comb begin
        state_d = state_q;
        busy_d  = busy;
        done_d  = 1'b0;
        if (compstart) begin
            state_d = SEARCH;
            busy_d  = 1'b1;
        end else if (early_exit) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State register with registered busy/compdone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            compdone <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= busy_d;
            compdone <= done_d;
        end
    end

    // Beat counter; cleared on window open and on early exit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (compstart || early_exit) begin
            cnt_q <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Stage 1: latch the per-beat winner with its vector.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_dist  <= '0;
            s1_lane  <= '0;
            s1_vx    <= '0;
            s1_vy    <= '0;
        end else begin
            s1_valid <= beat && !early_exit;
            if (beat) begin
                s1_dist <= sel_dist;
                s1_lane <= sel_lane;
                s1_vx   <= vectorx;
                s1_vy   <= vectory;
            end
        end
    end

    // Stage 2: strictly smaller candidate replaces the running best.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bestdist  <= '1;
            motionx   <= '0;
            motiony   <= '0;
            bestpe    <= '0;
            bestvalid <= 1'b0;
        end else if (compstart) begin
            bestdist  <= '1;
            bestvalid <= 1'b0;
        end else if (s2_hit) begin
            bestdist  <= s1_dist;
            motionx   <= s1_vx;
            motiony   <= s1_vy;
            bestpe    <= s1_lane;
            bestvalid <= 1'b1;
        end
    end

endmodule
